// File: rtl/iloop_sched_pkg.sv
// iloop_sched_pkg: shared state encoding and channel-index width helper for iloop_sched.
package iloop_sched_pkg;
  typedef enum logic [2:0] {IDLE, SETUP, STROBE, WAIT, STORE} state_t;
  function automatic int chw(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/iloop_sched_if.sv
// iloop_sched_if: scheduler-to-loop-core bus; master is the scheduler, slave the shared core.
interface iloop_sched_if import iloop_sched_pkg::*; #(
  parameter int NCH = 4,
  parameter int WIN = 16,
  parameter int WKI = 16,
  parameter int WOUT = 16
) ();
  logic [chw(NCH)-1:0] lp_ch;
  logic [WIN-1:0] lp_errin;
  logic [WKI-1:0] lp_ki;
  logic lp_reverse;
  logic lp_reset;
  logic lp_strobe_in;
  logic lp_strobe_out;
  logic [WOUT-1:0] lp_ctrl_out;
  modport master (output lp_ch, lp_errin, lp_ki, lp_reverse, lp_reset, lp_strobe_in, input lp_strobe_out, lp_ctrl_out);
  modport slave (input lp_ch, lp_errin, lp_ki, lp_reverse, lp_reset, lp_strobe_in, output lp_strobe_out, lp_ctrl_out);
endinterface

// File: rtl/iloop_sched_rr_arbiter.sv
// rr_arbiter: round-robin pick of the first requester after ptr, as one-hot grant plus index.
module rr_arbiter #(
  parameter int N = 4,
  parameter int W = 2
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [N-1:0] gnt,
  output logic [W-1:0] idx,
  output logic         any
);
  int j;
  // Scanning from the farthest offset down leaves the nearest requester after ptr as the winner.
  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    j = 0;
    for (int i = N; i >= 1; i--) begin
      j = (int'(ptr) + i) % N;
      if (req[j]) begin
        gnt = N'(1) << j;
        idx = W'(j);
        any = 1'b1;
      end
    end
  end
endmodule

// File: rtl/iloop_sched.sv
// iloop_sched: round-robin time-sharing of one multi-context integral-loop core among NCH channels.
module iloop_sched import iloop_sched_pkg::*; #(
  parameter int NCH = 4,
  parameter int WIN = 16,
  parameter int WKI = 16,
  parameter int WOUT = 16,
  parameter int TMO = 15
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NCH-1:0]      req_valid,
  input  logic [NCH*WIN-1:0]  req_err,
  output logic [NCH-1:0]      req_ready,
  input  logic [NCH*WKI-1:0]  cfg_ki,
  input  logic [NCH-1:0]      cfg_reverse,
  input  logic [NCH-1:0]      cfg_clear,
  iloop_sched_if.master       lp,
  output logic [NCH*WOUT-1:0] ch_ctrl,
  output logic [NCH-1:0]      ch_upd,
  output logic                timeout_err,
  output logic                busy
);
  localparam int CW = chw(NCH);
  localparam int TW = $clog2(TMO);
  state_t state;
  logic [CW-1:0] ptr, idx;
  logic [NCH-1:0] clr_pend, gnt;
  logic any, fire;
  logic [TW-1:0] cnt;
  rr_arbiter #(.N(NCH), .W(CW)) u_arb (.req(req_valid | clr_pend), .ptr(ptr), .gnt(gnt), .idx(idx), .any(any));
  assign fire = rst_n && state == IDLE && any;
  assign req_ready = fire ? gnt & req_valid : '0;
  assign busy = state != IDLE;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      ptr <= CW'(NCH - 1);
      clr_pend <= '0;
      cnt <= '0;
      lp.lp_ch <= '0;
      lp.lp_errin <= '0;
      lp.lp_ki <= '0;
      lp.lp_reverse <= 1'b0;
      lp.lp_reset <= 1'b0;
      lp.lp_strobe_in <= 1'b0;
      ch_ctrl <= '0;
      ch_upd <= '0;
      timeout_err <= 1'b0;
    end else begin
      clr_pend <= (clr_pend & ~(fire ? gnt : '0)) | cfg_clear;
      ch_upd <= '0;
      lp.lp_strobe_in <= 1'b0;
      case (state)
        IDLE: if (any) begin
          lp.lp_ch <= idx;
          lp.lp_errin <= req_valid[idx] ? req_err[idx*WIN +: WIN] : '0;
          lp.lp_ki <= cfg_ki[idx*WKI +: WKI];
          lp.lp_reverse <= cfg_reverse[idx];
          lp.lp_reset <= clr_pend[idx];
          ptr <= idx;
          state <= SETUP;
        end
        SETUP: begin
          lp.lp_strobe_in <= 1'b1;
          state <= STROBE;
        end
        STROBE: begin
          cnt <= '0;
          state <= WAIT;
        end
        // strobe_out is accepted through the (TMO-1)th cycle after the strobe; the flag shows TMO cycles after it
        WAIT: if (lp.lp_strobe_out) begin
          ch_ctrl[lp.lp_ch*WOUT +: WOUT] <= lp.lp_ctrl_out;
          ch_upd[lp.lp_ch] <= 1'b1;
          state <= STORE;
        end else if (cnt == TW'(TMO - 2)) begin
          timeout_err <= 1'b1;
          state <= IDLE;
        end else begin
          cnt <= cnt + 1'b1;
        end
        STORE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_iloop_sched.sv
// tb_iloop_sched: directed checks of iloop_sched against a two-cycle-latency core model.
module tb_iloop_sched;
  localparam int NCH = 4, WIN = 16, WKI = 16, WOUT = 16, TMO = 15;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [NCH-1:0] req_valid, req_ready, cfg_reverse, cfg_clear, ch_upd, upd;
  logic [NCH*WIN-1:0] req_err;
  logic [NCH*WKI-1:0] cfg_ki;
  logic [NCH*WOUT-1:0] ch_ctrl;
  logic timeout_err, busy, core_en, d1;
  int pass = 0, total = 0;
  iloop_sched_if #(.NCH(NCH), .WIN(WIN), .WKI(WKI), .WOUT(WOUT)) lp ();
  iloop_sched #(.NCH(NCH), .WIN(WIN), .WKI(WKI), .WOUT(WOUT), .TMO(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_err(req_err), .req_ready(req_ready),
    .cfg_ki(cfg_ki), .cfg_reverse(cfg_reverse), .cfg_clear(cfg_clear), .lp(lp),
    .ch_ctrl(ch_ctrl), .ch_upd(ch_upd), .timeout_err(timeout_err), .busy(busy));
  always #5 clk = ~clk;
  // Core model: result strobe two cycles after strobe_in, control output echoes the error input.
  always @(posedge clk) begin
    d1 <= lp.lp_strobe_in & core_en;
    lp.lp_strobe_out <= d1;
    lp.lp_ctrl_out <= lp.lp_errin;
  end
  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end
  task automatic nxt;
    @(negedge clk);
    #1;
  endtask
  task automatic do_reset;
    rst_n = 1'b0;
    req_valid = '0; req_err = '0; cfg_ki = '0; cfg_reverse = '0; cfg_clear = '0; core_en = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask
  task automatic test_reset;
    rst_n = 1'b0;
    req_valid = '1; req_err = '0; cfg_ki = '0; cfg_reverse = '0; cfg_clear = '1; core_en = 1'b1;
    nxt; nxt;
    total++; if (req_ready !== 4'b0) $display("FAIL rst_ready got %b want 0000", req_ready); else pass++;
    total++; if (busy !== 1'b0) $display("FAIL rst_busy got %b want 0", busy); else pass++;
    total++; if ({lp.lp_ch, lp.lp_errin, lp.lp_ki, lp.lp_reverse, lp.lp_reset, lp.lp_strobe_in} !== '0) $display("FAIL rst_lp got %h want 0", {lp.lp_ch, lp.lp_errin, lp.lp_ki}); else pass++;
    total++; if (ch_ctrl !== '0 || ch_upd !== '0 || timeout_err !== 1'b0) $display("FAIL rst_out got %h/%b/%b want 0", ch_ctrl, ch_upd, timeout_err); else pass++;
    req_valid = '0; cfg_clear = '0; rst_n = 1'b1;
    nxt; nxt;
    total++; if (busy !== 1'b0) $display("FAIL rst_clrpend busy got %b want 0", busy); else pass++;
  endtask
  task automatic test_single;
    do_reset;
    nxt;
    req_valid = 4'b0010; req_err[16 +: 16] = 16'd100; cfg_ki[16 +: 16] = 16'd128;
    #1;
    total++; if (req_ready !== 4'b0010) $display("FAIL single_ready got %b want 0010", req_ready); else pass++;
    nxt;
    req_valid = '0;
    total++; if (lp.lp_ch !== 2'd1 || lp.lp_errin !== 16'd100 || lp.lp_ki !== 16'd128) $display("FAIL single_lp got %0d/%0d/%0d want 1/100/128", lp.lp_ch, lp.lp_errin, lp.lp_ki); else pass++;
    total++; if (lp.lp_strobe_in !== 1'b0) $display("FAIL single_stb_early got %b want 0", lp.lp_strobe_in); else pass++;
    nxt;
    total++; if (lp.lp_strobe_in !== 1'b1) $display("FAIL single_stb got %b want 1", lp.lp_strobe_in); else pass++;
    nxt; nxt;
    total++; if (ch_upd !== 4'b0) $display("FAIL single_upd_early got %b want 0000", ch_upd); else pass++;
    nxt;
    total++; if (ch_upd !== 4'b0010) $display("FAIL single_upd got %b want 0010", ch_upd); else pass++;
    total++; if (ch_ctrl[16 +: 16] !== 16'h0064) $display("FAIL single_ctrl got %h want 0064", ch_ctrl[16 +: 16]); else pass++;
    nxt;
    total++; if (ch_upd !== 4'b0 || busy !== 1'b0) $display("FAIL single_done got %b/%b want 0000/0", ch_upd, busy); else pass++;
  endtask
  task automatic test_round_robin;
    do_reset;
    nxt;
    req_valid = 4'b1111; req_err = {16'd40, 16'd30, 16'd20, 16'd10};
    #1;
    for (int k = 0; k < 5; k++) begin
      total++; if (req_ready !== 4'(1 << (k % 4))) $display("FAIL rr_ready%0d got %b want %b", k, req_ready, 4'(1 << (k % 4))); else pass++;
      nxt;
      total++; if (lp.lp_ch !== 2'(k % 4)) $display("FAIL rr_ch%0d got %0d want %0d", k, lp.lp_ch, k % 4); else pass++;
      repeat (4) nxt;
      total++; if (ch_upd !== 4'(1 << (k % 4)) || ch_ctrl[(k % 4)*16 +: 16] !== 16'(10 * (k % 4 + 1))) $display("FAIL rr_upd%0d got %b/%0d want %b/%0d", k, ch_upd, ch_ctrl[(k % 4)*16 +: 16], 4'(1 << (k % 4)), 10 * (k % 4 + 1)); else pass++;
      nxt;
    end
    req_valid = '0;
  endtask
  task automatic test_clear;
    do_reset;
    nxt;
    cfg_clear = 4'b0100; cfg_reverse = 4'b0100; req_err[32 +: 16] = 16'h1234;
    nxt;
    cfg_clear = 4'b0100;
    #1;
    total++; if (req_ready !== 4'b0) $display("FAIL clr_ready got %b want 0000", req_ready); else pass++;
    nxt;
    cfg_clear = '0;
    total++; if (lp.lp_ch !== 2'd2 || lp.lp_reset !== 1'b1 || lp.lp_errin !== 16'd0 || lp.lp_reverse !== 1'b1) $display("FAIL clr_lp got %0d/%b/%h/%b want 2/1/0000/1", lp.lp_ch, lp.lp_reset, lp.lp_errin, lp.lp_reverse); else pass++;
    repeat (4) nxt;
    total++; if (ch_upd !== 4'b0100) $display("FAIL clr_upd got %b want 0100", ch_upd); else pass++;
    nxt;
    total++; if (req_ready !== 4'b0) $display("FAIL clr2_ready got %b want 0000", req_ready); else pass++;
    nxt;
    total++; if (busy !== 1'b1 || lp.lp_reset !== 1'b1 || lp.lp_ch !== 2'd2) $display("FAIL clr2_grant got %b/%b/%0d want 1/1/2", busy, lp.lp_reset, lp.lp_ch); else pass++;
    repeat (6) nxt;
    total++; if (busy !== 1'b0) $display("FAIL clr_drained busy got %b want 0", busy); else pass++;
  endtask
  task automatic test_timeout;
    do_reset;
    core_en = 1'b0;
    nxt;
    req_valid = 4'b0001; req_err[0 +: 16] = 16'd5;
    #1;
    total++; if (req_ready !== 4'b0001) $display("FAIL tmo_ready got %b want 0001", req_ready); else pass++;
    nxt;
    req_valid = 4'b0010; req_err[16 +: 16] = 16'd9;
    upd = '0;
    repeat (15) begin
      nxt;
      upd |= ch_upd;
    end
    total++; if (timeout_err !== 1'b0) $display("FAIL tmo_early got %b want 0", timeout_err); else pass++;
    nxt;
    core_en = 1'b1;
    upd |= ch_upd;
    total++; if (timeout_err !== 1'b1 || busy !== 1'b0) $display("FAIL tmo_flag got %b/%b want 1/0", timeout_err, busy); else pass++;
    total++; if (upd !== 4'b0) $display("FAIL tmo_noupd got %b want 0000", upd); else pass++;
    total++; if (req_ready !== 4'b0010) $display("FAIL tmo_resume got %b want 0010", req_ready); else pass++;
    nxt;
    req_valid = '0;
    repeat (4) nxt;
    total++; if (ch_upd !== 4'b0010 || ch_ctrl[16 +: 16] !== 16'd9 || timeout_err !== 1'b1) $display("FAIL tmo_after got %b/%0d/%b want 0010/9/1", ch_upd, ch_ctrl[16 +: 16], timeout_err); else pass++;
  endtask
  task automatic test_reset_mid;
    do_reset;
    nxt;
    req_valid = 4'b1000; req_err[48 +: 16] = 16'd77;
    nxt;
    req_valid = '0;
    nxt; nxt;
    rst_n = 1'b0;
    #1;
    total++; if (busy !== 1'b0 || lp.lp_ch !== 2'd0 || lp.lp_errin !== 16'd0) $display("FAIL mid_async got %b/%0d/%0d want 0/0/0", busy, lp.lp_ch, lp.lp_errin); else pass++;
    nxt;
    rst_n = 1'b1;
    upd = '0;
    repeat (4) begin
      nxt;
      upd |= ch_upd;
    end
    total++; if (upd !== 4'b0 || ch_ctrl !== '0) $display("FAIL mid_late got %b/%h want 0000/0", upd, ch_ctrl); else pass++;
    total++; if (busy !== 1'b0 || timeout_err !== 1'b0) $display("FAIL mid_idle got %b/%b want 0/0", busy, timeout_err); else pass++;
  endtask
  initial begin
    test_reset;
    test_single;
    test_round_robin;
    test_clear;
    test_timeout;
    test_reset_mid;
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule
